// File: rtl/asm_display_sched_if.sv
// ---------------------------------------------------------------------------
// asm_display_sched_if
//  Bundle of the display scheduler's board-facing signals: debounced button
//  pulses, the shared seven-segment lookup bus and the anode/segment drive.
//
//  btn_up/down/left/right  1  one-cycle cursor move pulses
//  btn_mode                1  one-cycle pulse, toggles letter-digit visibility
//  ssd_in                  7  segment code returned by the lookup block (active-low)
//  row_out/col_out         3  cursor coordinates presented to the lookup block
//  alpha_out               1  lookup select: letter (1) or numeric (0)
//  r_c_out                 1  numeric select: row (1) or col (0)
//  an                      4  anode enables, active-low, an[0] = rightmost
//  seg                     7  segment drive, active-low
//
//  master : board/bench side (drives buttons and the lookup result)
//  slave  : scheduler side
// ---------------------------------------------------------------------------
interface asm_display_sched_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_mode;
  logic [6:0] ssd_in;
  logic [2:0] row_out;
  logic [2:0] col_out;
  logic       alpha_out;
  logic       r_c_out;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_mode, ssd_in,
    input  row_out, col_out, alpha_out, r_c_out, an, seg
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_mode, ssd_in,
    output row_out, col_out, alpha_out, r_c_out, an, seg
  );
endinterface

// File: rtl/asm_display_sched.sv
// ---------------------------------------------------------------------------
// asm_display_sched
//  Cursor/scan controller for a 4-digit seven-segment display. Keeps a
//  cursor (row 1..4, col 1..5) moved by button pulses and time-multiplexes
//  one external combinational lookup block across the four digits:
//    slot0 -> col digit, slot1 -> row digit, slot2 -> blank spacer,
//    slot3 -> cursor letter (blanked when mode = 0).
//  Each slot is BLANK_CYC clocks with all anodes off followed by REFRESH_DIV
//  clocks with its anode lit.
//
//  clk  : system clock, rising edge
//  rst  : synchronous reset, active-high
//  bus  : asm_display_sched_if.slave (buttons, lookup bus, an/seg drive)
// ---------------------------------------------------------------------------
module asm_display_sched #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic               clk,
  input  logic               rst,
  asm_display_sched_if.slave bus
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [6:0]  SEG_OFF = 7'b1111111;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [2:0]    row_q, row_d, col_q, col_d;
  logic          mode_q, mode_d;
  logic [2:0]    lk_row_q, lk_row_d, lk_col_q, lk_col_d;
  logic          lk_alpha_q, lk_alpha_d, lk_rc_q, lk_rc_d;
  logic [6:0]    seg_q, seg_d;

  logic blank_first, blank_last, drive_last;

  // One shared phase counter: it counts 0..BLANK_CYC-1 in BLANK and
  // 0..REFRESH_DIV-1 in DRIVE, restarting at every state change.
  assign blank_first = (state_q == ST_BLANK) && (cnt_q == '0);
  assign blank_last  = (state_q == ST_BLANK) && (cnt_q == CW'(BLANK_CYC - 1));
  assign drive_last  = (state_q == ST_DRIVE) && (cnt_q == CW'(REFRESH_DIV - 1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of process ordering.
    if (rst) state_q <= ST_BLANK;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if (blank_last) state_d = ST_DRIVE;
      ST_DRIVE: if (drive_last) state_d = ST_BLANK;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state: counter, slot, cursor, lookup inputs, segments
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    slot_d     = slot_q;
    row_d      = row_q;
    col_d      = col_q;
    mode_d     = mode_q ^ bus.btn_mode;
    lk_row_d   = lk_row_q;
    lk_col_d   = lk_col_q;
    lk_alpha_d = lk_alpha_q;
    lk_rc_d    = lk_rc_q;
    seg_d      = seg_q;

    if (blank_last) cnt_d = '0;
    if (drive_last) begin
      cnt_d  = '0;
      slot_d = slot_q + 2'd1;
    end

    // Opposing pulses cancel; row and col move independently.
    if (bus.btn_up && !bus.btn_down)
      row_d = (row_q == 3'd1) ? 3'd4 : row_q - 3'd1;
    else if (bus.btn_down && !bus.btn_up)
      row_d = (row_q == 3'd4) ? 3'd1 : row_q + 3'd1;

    if (bus.btn_left && !bus.btn_right)
      col_d = (col_q == 3'd1) ? 3'd5 : col_q - 3'd1;
    else if (bus.btn_right && !bus.btn_left)
      col_d = (col_q == 3'd5) ? 3'd1 : col_q + 3'd1;

    // Snapshot the cursor once per slot; the lookup then has the rest of
    // BLANK to settle before its result is captured.
    if (blank_first) begin
      lk_row_d   = row_q;
      lk_col_d   = col_q;
      lk_alpha_d = (slot_q == 2'd3);
      lk_rc_d    = (slot_q == 2'd1);
    end

    if (blank_last) begin
      if (slot_q == 2'd2 || (slot_q == 2'd3 && !mode_q)) seg_d = SEG_OFF;
      else                                               seg_d = bus.ssd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      slot_q     <= 2'd0;
      row_q      <= 3'd1;
      col_q      <= 3'd1;
      mode_q     <= 1'b1;
      lk_row_q   <= 3'd1;
      lk_col_q   <= 3'd1;
      lk_alpha_q <= 1'b0;
      lk_rc_q    <= 1'b0;
      seg_q      <= SEG_OFF;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      row_q      <= row_d;
      col_q      <= col_d;
      mode_q     <= mode_d;
      lk_row_q   <= lk_row_d;
      lk_col_q   <= lk_col_d;
      lk_alpha_q <= lk_alpha_d;
      lk_rc_q    <= lk_rc_d;
      seg_q      <= seg_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (anodes decoded from registered state only)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.an = 4'b1111;
    if (state_q == ST_DRIVE) bus.an = ~(4'b0001 << slot_q);
    bus.seg       = seg_q;
    bus.row_out   = lk_row_q;
    bus.col_out   = lk_col_q;
    bus.alpha_out = lk_alpha_q;
    bus.r_c_out   = lk_rc_q;
  end

endmodule
